// File: rtl/hdg_err_gen_pkg.sv
// Shared types and constants for the heading-error producer.
// Optional build macro: ERR_RAMP_EN enables the target slew limiter.
package hdg_err_gen_pkg;

    localparam int HDG_W = 12;
    localparam int ERR_W = 10;

`ifdef ERR_RAMP_EN
    localparam int RAMP_STEP = 64;
`endif

    typedef logic signed [HDG_W-1:0] hdg_t;
    typedef logic signed [ERR_W-1:0] err_t;

    typedef enum logic [1:0] {
        IDLE,
        TRACK,
        SETTLED
    } settle_state_t;

    // Magnitude of a saturated error, one bit wider so |-512| is 512.
    function automatic logic [ERR_W:0] err_mag(input logic signed [ERR_W-1:0] e);
        logic signed [ERR_W:0] ext;
        ext = {e[ERR_W-1], e};
        if (ext[ERR_W]) ext = -ext;
        return ext;
    endfunction

endpackage

// File: rtl/hdg_err_gen_sat.sv
// Combinational signed saturator: clamps an IN_W signed value into OUT_W signed range.
module hdg_err_gen_sat #(
    parameter int IN_W  = 12,
    parameter int OUT_W = 10
) (
    input  logic signed [IN_W-1:0]  din,
    output logic signed [OUT_W-1:0] dout
);

    localparam logic signed [IN_W-1:0] MAX_V = IN_W'((2 ** (OUT_W - 1)) - 1);
    localparam logic signed [IN_W-1:0] MIN_V = IN_W'(-(2 ** (OUT_W - 1)));

    // clamp to the output range, otherwise pass the low bits through
    always_comb begin
        if (din > MAX_V)
            dout = MAX_V[OUT_W-1:0];
        else if (din < MIN_V)
            dout = MIN_V[OUT_W-1:0];
        else
            dout = din[OUT_W-1:0];
    end

endmodule

// File: rtl/hdg_err_gen.sv
// Heading error producer: gyro heading samples -> saturated error stream plus
// a settled flag (at_hdg) for the move sequencer.
// Optional build macro: ERR_RAMP_EN (target slews toward dsrd_hdg by RAMP_STEP per sample).
//
//  state   | meaning
//  --------+-----------------------------------------------------------
//  IDLE    | not moving; settle count held at 0, at_hdg low
//  TRACK   | moving, fewer than AT_CNT consecutive on-heading samples
//  SETTLED | moving, AT_CNT consecutive on-heading samples, at_hdg high
module hdg_err_gen
    import hdg_err_gen_pkg::*;
#(
    parameter int AT_THRESH = 32,
    parameter int AT_CNT    = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    moving,
    input  logic                    hdg_vld,
    input  logic signed [HDG_W-1:0] heading,
    input  logic signed [HDG_W-1:0] dsrd_hdg,
    output logic signed [ERR_W-1:0] err_sat,
    output logic                    err_vld,
    output logic                    at_hdg
);

    localparam logic [ERR_W:0] THR_V   = (ERR_W + 1)'(AT_THRESH);
    localparam logic [7:0]     CNT_MAX = 8'(AT_CNT);

    hdg_t          hdg_q;
    logic          vld_q;
    hdg_t          dsrd_q;
    hdg_t          target;
    logic          tgt_done;
    logic          tgt_chg;
    hdg_t          err_raw;
    err_t          err_sat_c;
    logic [7:0]    cnt;
    logic [7:0]    cnt_nxt;
    settle_state_t state;
    settle_state_t state_nxt;

    assign tgt_chg = (dsrd_hdg != dsrd_q);
    // modular subtraction: the wrap at +/-2^(HDG_W-1) is the shortest-path error
    assign err_raw = hdg_q - target;

    hdg_err_gen_sat #(
        .IN_W (HDG_W),
        .OUT_W(ERR_W)
    ) u_sat (
        .din (err_raw),
        .dout(err_sat_c)
    );

    // registered copy of the desired heading, used for change detection
    always_ff @(posedge clk or posedge rst) begin
        if (rst) dsrd_q <= '0;
        else     dsrd_q <= dsrd_hdg;
    end

`ifdef ERR_RAMP_EN
    localparam hdg_t STEP_P = HDG_W'(RAMP_STEP);
    localparam hdg_t STEP_N = HDG_W'(-RAMP_STEP);

    hdg_t tgt_q;
    hdg_t tgt_diff;
    hdg_t tgt_step;
    logic init_q;

    // shortest-path difference to the desired heading, clipped to one ramp step
    always_comb begin
        tgt_diff = dsrd_hdg - tgt_q;
        tgt_step = tgt_diff;
        if (tgt_diff > STEP_P)
            tgt_step = STEP_P;
        else if (tgt_diff < STEP_N)
            tgt_step = STEP_N;
    end

    // slewed target: snaps after reset or while stopped, steps once per sample otherwise
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tgt_q  <= '0;
            init_q <= 1'b0;
        end else begin
            init_q <= 1'b1;
            if (!init_q || !moving)
                tgt_q <= dsrd_hdg;
            else if (hdg_vld)
                tgt_q <= tgt_q + tgt_step;
        end
    end

    assign target   = tgt_q;
    assign tgt_done = (tgt_q == dsrd_hdg);
`else
    assign target   = dsrd_q;
    assign tgt_done = 1'b1;
`endif

    // capture stage: heading and its valid bit
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hdg_q <= '0;
            vld_q <= 1'b0;
        end else begin
            vld_q <= hdg_vld;
            if (hdg_vld) hdg_q <= heading;
        end
    end

    // error stage: saturated error held between strobes
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_sat <= '0;
            err_vld <= 1'b0;
        end else begin
            err_vld <= vld_q;
            if (vld_q) err_sat <= err_sat_c;
        end
    end

    // next settle count; stop and target change override any same-cycle sample
    always_comb begin
        cnt_nxt = cnt;
        if (!moving || tgt_chg)
            cnt_nxt = '0;
        else if (err_vld) begin
            if (err_mag(err_sat) <= THR_V)
                cnt_nxt = (cnt >= CNT_MAX) ? CNT_MAX : cnt + 8'd1;
            else
                cnt_nxt = '0;
        end
    end

    // next settle state from the updated count
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (moving)
                    state_nxt = (cnt_nxt == CNT_MAX && tgt_done) ? SETTLED : TRACK;
            end
            default: begin
                if (!moving)
                    state_nxt = IDLE;
                else if (cnt_nxt == CNT_MAX && tgt_done)
                    state_nxt = SETTLED;
                else
                    state_nxt = TRACK;
            end
        endcase
    end

    // settle FSM with registered count and at_hdg
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            cnt    <= '0;
            at_hdg <= 1'b0;
        end else begin
            state  <= state_nxt;
            cnt    <= cnt_nxt;
            at_hdg <= (state_nxt == SETTLED);
        end
    end

endmodule
